mso_decimator: RTL and testbench
================================

Name: mso_decimator

Overview:
- Downstream neighbour of the FIR low-pass stage in the MSO acquisition path. Consumes the filtered signed sample stream and reduces its rate by a runtime ratio R.
- Every R input samples it emits one record: {last sample, window min, window max}. This supports both plain subsampling and peak-detect display modes.
- Output goes through a 2-entry buffer with valid/ready handshake toward the capture memory writer.
- The input side cannot stall; results that cannot be buffered are dropped and flagged.

Parameters:
- DATA_WIDTH, 12, signed sample width on input and all output data fields.
- RATIO_WIDTH, 8, width of the decimation ratio input.

Ports:
- clk  in  1  sample clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  decimation run enable.
- ratio  in  RATIO_WIDTH  decimation ratio R; values 0 and 1 both mean R=1.
- in_data  in  DATA_WIDTH  signed filtered sample.
- in_valid  in  1  in_data valid this cycle.
- out_data  out  DATA_WIDTH  last sample of the window.
- out_min  out  DATA_WIDTH  signed minimum over the window.
- out_max  out  DATA_WIDTH  signed maximum over the window.
- out_valid  out  1  output record valid.
- out_ready  in  1  consumer accepts the record.
- overflow  out  1  sticky: a window result was dropped.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset: async on rst high. All outputs 0, counter 0, buffer empty, overflow 0, latched ratio = 1.
- Window counter cnt, 0..R-1, advances only on in_valid && enable.
- R is latched from ratio when a sample is accepted at cnt==0. A ratio change mid-window therefore takes effect at the next window.
- Sample at cnt==0 initialises the accumulators: run_min = run_max = in_data.
- Later samples in the window update them: run_min = signed min(run_min, in_data); run_max = signed max(run_max, in_data).
- All comparisons are signed two's complement at DATA_WIDTH. There is no width growth.
- Window completes on the sample accepted at cnt==R-1 (with R=1, every sample completes a window).
- On completion, the record {in_data, min incl. in_data, max incl. in_data} is pushed into the buffer, and cnt returns to 0.
- Latency: out_valid rises the cycle after the completing sample's clock edge, provided the buffer was empty. That is 1 register stage.
- Buffer: 2-entry FIFO. out_* always present the head entry; out_valid = not empty.
- A pop occurs on out_valid && out_ready.
- out_data/out_min/out_max must hold stable while out_valid && !out_ready.
- Push while full and no pop in the same cycle: the record is dropped, overflow is set, and buffer contents are unchanged.
- Push while full with a pop in the same cycle: the push is accepted, with no overflow.
- Push and pop when the buffer holds 1 entry: occupancy stays 1 and the head advances to the new record.
- overflow stays 1 until ovf_clr. If ovf_clr and a new drop occur in the same cycle, the drop wins and overflow stays 1.
- enable low: cnt is forced to 0 and the partial window is discarded (no emit). in_valid is ignored.
- The buffer keeps draining normally while enable is low.
- Reset mid-window or mid-handshake: everything is cleared immediately, including buffered records.
- in_valid low: no state change in the window logic.

Decomposition:
- Package mso_pkg: DATA_WIDTH default constant, record typedef {data, min, max}, and signed min/max helper functions.
- One sub-module, mso_fifo2: 2-entry synchronous FIFO with push, pop, full, empty, and head data. It must support simultaneous push/pop when full.
- Window counter and accumulators stay in mso_decimator.

Test Plan:
- R=1, enable=1, out_ready=1, inputs -3,1,0 on consecutive cycles -> three records, each with data=min=max=input, each 1 cycle after its input, overflow=0.
- R=4, samples 0,-3,1,0,-2,-1,4,-5, out_ready=1 -> exactly two records: {0,-3,1} and {-5,-5,4}.
- R=2, out_ready=0, 8 samples -> first two records held stable in the buffer. 3rd and 4th are dropped and overflow=1. Then out_ready=1 -> records 1 and 2 are popped in order. ovf_clr -> overflow=0.
- R=3, ratio changed to 5 after the 2nd sample of a window -> the current window closes after 3 samples and the next after 5.
- R=4, enable deasserted after 2 samples, then re-asserted with 4 samples 7,7,7,-8 -> only one record, {-8,-8,7}, with no partial-window emit.
- Buffer full with out_ready=1 while a window completes -> push is accepted, occupancy stays 2, overflow stays 0. Then rst pulse mid-stream -> out_valid=0 and all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/mso_pkg.sv
// Shared constants, record layout and signed compare helpers for the MSO decimator.
package mso_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 12;
    localparam int unsigned DEF_RATIO_WIDTH = 8;

    // One decimated window result at the default sample width.
    typedef struct packed {
        logic signed [DEF_DATA_WIDTH-1:0] data;
        logic signed [DEF_DATA_WIDTH-1:0] vmin;
        logic signed [DEF_DATA_WIDTH-1:0] vmax;
    } rec_t;

    // Operands are sign-extended to 32 bits by the caller so any sample width up to 32 works.
    function automatic logic signed [31:0] smin(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mso_fifo2.sv
// Two-entry FIFO; head is always entry 0, and a push is accepted when full if a pop happens too.
module mso_fifo2 #(
    parameter int unsigned WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
    logic             v0_q, v0_d, v1_q, v1_d;
    logic             pop_ok_c, push_ok_c;

    always_comb begin
        mem0_d    = mem0_q;
        mem1_d    = mem1_q;
        v0_d      = v0_q;
        v1_d      = v1_q;
        pop_ok_c  = pop_i && v0_q;
        push_ok_c = push_i && (!v1_q || pop_ok_c);

        if (pop_ok_c) begin
            mem0_d = mem1_q;
            v0_d   = v1_q;
            v1_d   = 1'b0;
        end

        // After a same-cycle pop the free slot is entry 1 if the FIFO was full, else entry 0.
        if (push_ok_c) begin
            if (pop_ok_c ? v1_q : v0_q) begin
                mem1_d = data_i;
                v1_d   = 1'b1;
            end else begin
                mem0_d = data_i;
                v0_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0_q <= '0;
            mem1_q <= '0;
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
        end else begin
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            v0_q   <= v0_d;
            v1_q   <= v1_d;
        end
    end

    assign head_o  = mem0_q;
    assign full_o  = v1_q;
    assign empty_o = !v0_q;

endmodule

// File: rtl/mso_decimator.sv
// Rate reducer emitting {last, min, max} per R-sample window into a 2-deep output buffer.
module mso_decimator
    import mso_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned RATIO_WIDTH = DEF_RATIO_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [RATIO_WIDTH-1:0]        ratio,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    input  logic                          in_valid,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    output logic signed [DATA_WIDTH-1:0]  out_min,
    output logic signed [DATA_WIDTH-1:0]  out_max,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int unsigned REC_W = 3 * DATA_WIDTH;

    logic [RATIO_WIDTH-1:0]       cnt_q, cnt_d, ratio_q, ratio_d, r_eff_c;
    logic signed [DATA_WIDTH-1:0] min_q, min_d, max_q, max_d, cur_min_c, cur_max_c;
    logic                         ovf_q, ovf_d;
    logic                         accept_c, first_c, complete_c, pop_c, drop_c;
    logic                         full_c, empty_c;
    logic [REC_W-1:0]             push_rec_c, head_c;

    always_comb begin
        accept_c = in_valid && enable;
        first_c  = (cnt_q == '0);

        // The ratio input is only sampled at window start; 0 is treated as 1.
        r_eff_c = ratio_q;
        if (first_c) begin
            r_eff_c = (ratio == '0) ? RATIO_WIDTH'(1) : ratio;
        end

        cur_min_c = in_data;
        cur_max_c = in_data;
        if (!first_c) begin
            cur_min_c = DATA_WIDTH'(smin(32'(min_q), 32'(in_data)));
            cur_max_c = DATA_WIDTH'(smax(32'(max_q), 32'(in_data)));
        end

        complete_c = accept_c && (cnt_q == RATIO_WIDTH'(r_eff_c - RATIO_WIDTH'(1)));
        pop_c      = !empty_c && out_ready;
        drop_c     = complete_c && full_c && !pop_c;
        push_rec_c = {in_data, cur_min_c, cur_max_c};

        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        min_d   = min_q;
        max_d   = max_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (accept_c) begin
            if (first_c) begin
                ratio_d = r_eff_c;
            end
            min_d = cur_min_c;
            max_d = cur_max_c;
            cnt_d = complete_c ? '0 : RATIO_WIDTH'(cnt_q + RATIO_WIDTH'(1));
        end

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (drop_c) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            ratio_q <= RATIO_WIDTH'(1);
            min_q   <= '0;
            max_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            min_q   <= min_d;
            max_q   <= max_d;
            ovf_q   <= ovf_d;
        end
    end

    mso_fifo2 #(
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (complete_c),
        .pop_i   (pop_c),
        .data_i  (push_rec_c),
        .head_o  (head_c),
        .full_o  (full_c),
        .empty_o (empty_c)
    );

    assign out_data  = head_c[REC_W-1 -: DATA_WIDTH];
    assign out_min   = head_c[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign out_max   = head_c[DATA_WIDTH-1:0];
    assign out_valid = !empty_c;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mso_decimator.sv
// Directed bench for mso_decimator with hand-computed expected records.
module tb_mso_decimator;

    localparam int unsigned DW = 12;
    localparam int unsigned RW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [RW-1:0] ratio = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] out_data, out_min, out_max;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          overflow;
    logic          ovf_clr = 1'b0;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mso_decimator #(
        .DATA_WIDTH  (DW),
        .RATIO_WIDTH (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ratio     (ratio),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_min   (out_min),
        .out_max   (out_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input int d, input int mn, input int mx);
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " data"}, {20'd0, out_data}, {20'd0, 12'(d)});
        chk({tag, " min"},  {20'd0, out_min},  {20'd0, 12'(mn)});
        chk({tag, " max"},  {20'd0, out_max},  {20'd0, 12'(mx)});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid"}, 32'(out_valid), 32'd0);
    endtask

    // Drive one input cycle at the falling edge, then sample just after the rising edge.
    task automatic step(input logic v, input int d);
        @(negedge clk);
        in_valid = v;
        in_data  = 12'(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid", 32'(out_valid), 32'd0);
        chk("rst data", {20'd0, out_data}, 32'd0);
        chk("rst min", {20'd0, out_min}, 32'd0);
        chk("rst max", {20'd0, out_max}, 32'd0);
        chk("rst ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // R=1: every sample is its own window
        ratio = 8'd1; enable = 1'b1; out_ready = 1'b1;
        step(1'b1, -3); chk_rec("r1 a", -3, -3, -3);
        step(1'b1, 1);  chk_rec("r1 b", 1, 1, 1);
        step(1'b1, 0);  chk_rec("r1 c", 0, 0, 0);
        chk("r1 ovf", 32'(overflow), 32'd0);
        step(1'b0, 0);  chk_idle("r1 drained");

        // R=4 peak detect
        ratio = 8'd4;
        step(1'b1, 0); step(1'b1, -3); step(1'b1, 1);
        chk_idle("r4 partial");
        step(1'b1, 0);  chk_rec("r4 w1", 0, -3, 1);
        step(1'b1, -2); chk_idle("r4 popped");
        step(1'b1, -1); step(1'b1, 4);
        chk_idle("r4 partial2");
        step(1'b1, -5); chk_rec("r4 w2", -5, -5, 4);
        step(1'b0, 0);  chk_idle("r4 drained");

        // R=2 with stalled consumer: fill, hold, drop
        ratio = 8'd2; out_ready = 1'b0;
        step(1'b1, 3); step(1'b1, -1);
        chk_rec("stall head", -1, -1, 3);
        step(1'b1, 5); step(1'b1, 6);
        chk_rec("stall hold1", -1, -1, 3);
        chk("stall ovf0", 32'(overflow), 32'd0);
        step(1'b1, 7); step(1'b1, 8);
        chk("stall ovf1", 32'(overflow), 32'd1);
        chk_rec("stall hold2", -1, -1, 3);
        step(1'b1, 9);
        ovf_clr = 1'b1;
        step(1'b1, 10);
        ovf_clr = 1'b0;
        chk("drop beats clr", 32'(overflow), 32'd1);
        chk_rec("stall hold3", -1, -1, 3);
        out_ready = 1'b1;
        step(1'b0, 0); chk_rec("stall pop2", 6, 5, 6);
        step(1'b0, 0); chk_idle("stall empty");
        chk("ovf sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        step(1'b0, 0);
        ovf_clr = 1'b0;
        chk("ovf cleared", 32'(overflow), 32'd0);

        // Ratio change mid-window applies to the next window
        ratio = 8'd3;
        step(1'b1, 1); step(1'b1, 2);
        ratio = 8'd5;
        step(1'b1, 3);   chk_rec("ratio w3", 3, 1, 3);
        step(1'b1, 10);  chk_idle("ratio p1");
        step(1'b1, -10); step(1'b1, 20); step(1'b1, -20);
        chk_idle("ratio p4");
        step(1'b1, 0);   chk_rec("ratio w5", 0, -20, 20);
        step(1'b0, 0);

        // enable low discards the partial window
        ratio = 8'd4;
        step(1'b1, 1); step(1'b1, 2);
        enable = 1'b0;
        step(1'b1, 3);  chk_idle("en off");
        enable = 1'b1;
        step(1'b1, 7); step(1'b1, 7); step(1'b1, 7);
        chk_idle("en partial");
        step(1'b1, -8); chk_rec("en w", -8, -8, 7);
        step(1'b0, 0);  chk_idle("en single");

        // Full buffer with simultaneous pop and push
        ratio = 8'd1; out_ready = 1'b0;
        step(1'b1, 11); step(1'b1, 12);
        chk_rec("full head", 11, 11, 11);
        out_ready = 1'b1;
        step(1'b1, 13); chk_rec("full pp", 12, 12, 12);
        chk("full pp ovf", 32'(overflow), 32'd0);
        step(1'b0, 0);  chk_rec("full 2nd", 13, 13, 13);
        step(1'b0, 0);  chk_idle("full drained");

        // Asynchronous reset mid-window with buffered records and overflow set
        out_ready = 1'b0;
        step(1'b1, 21); step(1'b1, 22); step(1'b1, 23);
        chk("pre-rst ovf", 32'(overflow), 32'd1);
        ratio = 8'd4;
        step(1'b1, 5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst valid", 32'(out_valid), 32'd0);
        chk("arst data", {20'd0, out_data}, 32'd0);
        chk("arst min", {20'd0, out_min}, 32'd0);
        chk("arst max", {20'd0, out_max}, 32'd0);
        chk("arst ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ratio = 8'd0; out_ready = 1'b1;
        step(1'b1, 9);  chk_rec("post rst r0", 9, 9, 9);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
